// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores over a req/ack data port, aligns and
// extends load data, and presents a registered writeback bundle to WB.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] IR,
    input  logic [31:0] alu_res,
    input  logic [31:0] B_res,
    input  logic [31:0] PC_res,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned CNT_W   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam int unsigned TO_LAST = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Context of the outstanding access, needed when the ack arrives
    logic              pend_ld_q, pend_ld_d;
    size_e             pend_size_q, pend_size_d;
    logic              pend_uns_q, pend_uns_d;
    logic [1:0]        pend_off_q, pend_off_d;
    logic [RD_W-1:0]   pend_rd_q, pend_rd_d;

    logic              in_ready_d;
    logic              dmem_req_d, dmem_we_d;
    logic [XLEN-1:0]   dmem_addr_d, dmem_wdata_d;
    logic [BE_W-1:0]   dmem_be_d;
    logic              out_valid_d, wb_en_d, err_d;
    logic [RD_W-1:0]   wb_rd_d;
    logic [XLEN-1:0]   wb_data_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [RD_W-1:0]   rd;
    logic              is_load, is_store, is_mem;
    size_e             acc_size;
    logic              acc_uns;
    logic              misaligned;
    logic [BE_W-1:0]   st_be;
    logic [XLEN-1:0]   st_wdata;
    logic              nm_wb_en;
    logic [XLEN-1:0]   nm_wb_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_value;
    logic              timed_out;

    logic unused_ir;
    assign unused_ir = ^IR[31:15];

    assign opcode = IR[6:0];
    assign funct3 = IR[14:12];
    assign rd     = IR[11:7];

    // Access size, alignment and store lane placement
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_mem   = is_load | is_store;
        acc_size = SZ_W;
        acc_uns  = 1'b0;
        case (funct3)
            3'b000:  acc_size = SZ_B;
            3'b001:  acc_size = SZ_H;
            3'b100:  if (is_load) begin acc_size = SZ_B; acc_uns = 1'b1; end
            3'b101:  if (is_load) begin acc_size = SZ_H; acc_uns = 1'b1; end
            default: acc_size = SZ_W;
        endcase

        misaligned = 1'b0;
        st_be      = '1;
        st_wdata   = B_res;
        case (acc_size)
            SZ_B: begin
                st_be    = BE_W'(4'b0001 << alu_res[1:0]);
                st_wdata = {4{B_res[7:0]}};
            end
            SZ_H: begin
                misaligned = alu_res[0];
                st_be      = BE_W'(4'b0011 << alu_res[1:0]);
                st_wdata   = {2{B_res[15:0]}};
            end
            default: misaligned = (alu_res[1:0] != 2'b00);
        endcase
    end

    // Writeback selection for bundles that retire without a memory access
    always_comb begin
        nm_wb_en   = 1'b1;
        nm_wb_data = alu_res;
        case (opcode)
            OP_JAL, OP_JALR:     nm_wb_data = PC_res + XLEN'(4);
            OP_BRANCH, OP_STORE: nm_wb_en   = 1'b0;
            default:             nm_wb_en   = 1'b1;
        endcase
        if (rd == '0) nm_wb_en = 1'b0;
    end

    // Load lane extraction and extension
    always_comb begin
        ld_byte  = 8'(dmem_rdata >> {pend_off_q, 3'b000});
        ld_half  = 16'(dmem_rdata >> {pend_off_q[1], 4'b0000});
        ld_value = dmem_rdata;
        case (pend_size_q)
            SZ_B: ld_value = pend_uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H: ld_value = pend_uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_value = dmem_rdata;
        endcase
    end

    assign timed_out = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_ld_d    = pend_ld_q;
        pend_size_d  = pend_size_q;
        pend_uns_d   = pend_uns_q;
        pend_off_d   = pend_off_q;
        pend_rd_d    = pend_rd_q;
        in_ready_d   = in_ready;
        dmem_req_d   = dmem_req;
        dmem_we_d    = dmem_we;
        dmem_addr_d  = dmem_addr;
        dmem_be_d    = dmem_be;
        dmem_wdata_d = dmem_wdata;
        out_valid_d  = 1'b0;
        wb_en_d      = wb_en;
        wb_rd_d      = wb_rd;
        wb_data_d    = wb_data;
        err_d        = err;

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid) begin
                    if (is_mem && !misaligned) begin
                        state_d      = S_WAIT;
                        cnt_d        = '0;
                        in_ready_d   = 1'b0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {alu_res[31:2], 2'b00};
                        dmem_be_d    = st_be;
                        dmem_wdata_d = st_wdata;
                        pend_ld_d    = is_load;
                        pend_size_d  = acc_size;
                        pend_uns_d   = acc_uns;
                        pend_off_d   = alu_res[1:0];
                        pend_rd_d    = rd;
                    end else begin
                        out_valid_d = 1'b1;
                        wb_rd_d     = rd;
                        err_d       = is_mem;
                        wb_en_d     = is_mem ? 1'b0 : nm_wb_en;
                        wb_data_d   = is_mem ? '0 : nm_wb_data;
                    end
                end
            end
            S_WAIT: begin
                in_ready_d = 1'b0;
                if (dmem_ack || timed_out) begin
                    state_d     = S_IDLE;
                    in_ready_d  = 1'b1;
                    dmem_req_d  = 1'b0;
                    dmem_we_d   = 1'b0;
                    dmem_be_d   = '0;
                    out_valid_d = 1'b1;
                    wb_rd_d     = pend_rd_q;
                    err_d       = !dmem_ack;
                    wb_en_d     = dmem_ack && pend_ld_q && (pend_rd_q != '0);
                    wb_data_d   = (dmem_ack && pend_ld_q) ? ld_value : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_ld_q   <= 1'b0;
            pend_size_q <= SZ_B;
            pend_uns_q  <= 1'b0;
            pend_off_q  <= '0;
            pend_rd_q   <= '0;
            in_ready    <= 1'b1;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            out_valid   <= 1'b0;
            wb_en       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_ld_q   <= pend_ld_d;
            pend_size_q <= pend_size_d;
            pend_uns_q  <= pend_uns_d;
            pend_off_q  <= pend_off_d;
            pend_rd_q   <= pend_rd_d;
            in_ready    <= in_ready_d;
            dmem_req    <= dmem_req_d;
            dmem_we     <= dmem_we_d;
            dmem_addr   <= dmem_addr_d;
            dmem_be     <= dmem_be_d;
            dmem_wdata  <= dmem_wdata_d;
            out_valid   <= out_valid_d;
            wb_en       <= wb_en_d;
            wb_rd       <= wb_rd_d;
            wb_data     <= wb_data_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, randomized bundles against a
// spec-level reference model, and hand sequences for reset/throughput corners.
module tb_mem_stage;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] IR, alu_res, B_res, PC_res;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid, wb_en, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .IR(IR), .alu_res(alu_res), .B_res(B_res), .PC_res(PC_res),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    typedef struct {
        string       name;
        logic [31:0] ir, alu, b, pc, rdata;
        int          ack_after;   // WAIT cycles without ack before ack; -1 = never
        int          req_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic        chk_lanes;
        logic [31:0] wdata;
        logic        en;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
        logic [4:0]  rd;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference behaviour written straight from the instruction semantics
    function automatic vec_t model(input logic [31:0] ir, alu, b, pc, rdata, input int ack_after);
        vec_t v;
        logic [6:0] op;
        logic [2:0] f3;
        int sz, off;
        bit uns, is_ld, is_st;
        logic [63:0] tmp;
        op = ir[6:0]; f3 = ir[14:12];
        v.name = "model"; v.ir = ir; v.alu = alu; v.b = b; v.pc = pc; v.rdata = rdata;
        v.ack_after = ack_after; v.req_cycles = 0; v.addr = 0; v.be = 0; v.we = 0;
        v.chk_lanes = 0; v.wdata = 0; v.en = 0; v.chk_data = 0; v.data = 0; v.err = 0;
        v.rd = ir[11:7];
        is_ld = (op == 7'b0000011);
        is_st = (op == 7'b0100011);
        sz = 4; uns = 0;
        if (is_ld) begin
            case (f3)
                3'd0: sz = 1;
                3'd1: sz = 2;
                3'd4: begin sz = 1; uns = 1; end
                3'd5: begin sz = 2; uns = 1; end
                default: sz = 4;
            endcase
        end else if (is_st) begin
            case (f3)
                3'd0: sz = 1;
                3'd1: sz = 2;
                default: sz = 4;
            endcase
        end
        if (is_ld || is_st) begin
            off = int'(alu[1:0]);
            if (off % sz != 0) begin
                v.err = 1;
            end else begin
                v.addr = alu - 32'(off);
                v.we = is_st;
                if (ack_after >= 0 && ack_after < int'(TO)) v.req_cycles = ack_after + 1;
                else begin v.req_cycles = int'(TO); v.err = 1; end
                if (is_st) begin
                    v.chk_lanes = 1;
                    v.be = 4'(((1 << sz) - 1) << off);
                    for (int i = 0; i < 4; i++) v.wdata[8*i +: 8] = b[8*(i % sz) +: 8];
                end
                if (!v.err) begin
                    v.chk_data = 1;
                    if (is_ld) begin
                        tmp = 64'(rdata >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
                        if (!uns && tmp[8*sz-1]) tmp = tmp - (64'd1 << (8 * sz));
                        v.data = tmp[31:0];
                        v.en = (v.rd != 0);
                    end
                end
            end
        end else if (op == 7'b1101111 || op == 7'b1100111) begin
            v.data = pc + 32'd4; v.chk_data = 1; v.en = (v.rd != 0);
        end else if (op != 7'b1100011) begin
            v.data = alu; v.chk_data = 1; v.en = (v.rd != 0);
        end
        return v;
    endfunction

    // Apply one bundle, act as memory, and compare the retired bundle
    task automatic run_vec(input vec_t v, input bit stray_ack);
        int req_n;
        bit seen, ready_ok, stable_ok;
        logic [31:0] a, wd, held;
        logic [3:0] be;
        logic we;
        req_n = 0; seen = 0; ready_ok = 1; stable_ok = 1; a = 0; wd = 0; be = 0; we = 0;
        @(negedge clk);
        IR = v.ir; alu_res = v.alu; B_res = v.b; PC_res = v.pc;
        in_valid = 1'b1; dmem_ack = stray_ack; dmem_rdata = $urandom;
        @(negedge clk);
        in_valid = 1'b0; IR = $urandom; alu_res = $urandom; B_res = $urandom; PC_res = $urandom;
        for (int c = 0; c < 20; c++) begin
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            if (out_valid) begin seen = 1; break; end
            if (dmem_req) begin
                req_n++;
                if (in_ready) ready_ok = 0;
                if (req_n == 1) begin a = dmem_addr; wd = dmem_wdata; be = dmem_be; we = dmem_we; end
                else if (a !== dmem_addr || wd !== dmem_wdata || be !== dmem_be || we !== dmem_we)
                    stable_ok = 0;
                if (req_n - 1 == v.ack_after) begin dmem_ack = 1'b1; dmem_rdata = v.rdata; end
            end
            @(negedge clk);
        end
        chk({v.name, " out_valid"}, 32'(seen), 32'd1);
        chk({v.name, " req_cycles"}, 32'(req_n), 32'(v.req_cycles));
        if (v.req_cycles > 0) begin
            chk({v.name, " addr"}, a, v.addr);
            chk({v.name, " we"}, 32'(we), 32'(v.we));
            chk({v.name, " ready_low"}, 32'(ready_ok), 32'd1);
            chk({v.name, " stable"}, 32'(stable_ok), 32'd1);
        end
        if (v.chk_lanes && v.req_cycles > 0) begin
            chk({v.name, " be"}, 32'(be), 32'(v.be));
            chk({v.name, " wdata"}, wd, v.wdata);
        end
        chk({v.name, " err"}, 32'(err), 32'(v.err));
        chk({v.name, " wb_en"}, 32'(wb_en), 32'(v.en));
        if (v.en) chk({v.name, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
        if (v.chk_data) chk({v.name, " wb_data"}, wb_data, v.data);
        chk({v.name, " ready_at_retire"}, 32'(in_ready), 32'd1);
        held = wb_data;
        @(negedge clk);
        chk({v.name, " pulse"}, 32'(out_valid), 32'd0);
        chk({v.name, " hold"}, wb_data, held);
        chk({v.name, " req_idle"}, 32'(dmem_req), 32'd0);
    endtask

    vec_t tbl[20];

    initial begin
        vec_t v;
        int r;
        logic [31:0] ir, alu;
        logic [6:0] ops[10];

        tbl[0]  = '{"addi",  32'h00500193, 32'h5, 32'h0, 32'h0, 32'h0, 0,  0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5, 1'b0, 5'd3};
        tbl[1]  = '{"sb",    32'h00000023, 32'h1003, 32'hAB, 32'h0, 32'h0, 2, 3, 32'h1000, 4'b1000, 1'b1, 1'b1, 32'hABABABAB, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0};
        tbl[2]  = '{"lb",    32'h00000283, 32'h2002, 32'h0, 32'h0, 32'h12F45678, 0, 1, 32'h2000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFF4, 1'b0, 5'd5};
        tbl[3]  = '{"lbu",   32'h00004283, 32'h2002, 32'h0, 32'h0, 32'h12F45678, 1, 2, 32'h2000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h000000F4, 1'b0, 5'd5};
        tbl[4]  = '{"lh",    32'h00001283, 32'h2002, 32'h0, 32'h0, 32'h12F45678, 0, 1, 32'h2000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h000012F4, 1'b0, 5'd5};
        tbl[5]  = '{"lh_neg",32'h00001283, 32'h2000, 32'h0, 32'h0, 32'h12348001, 1, 2, 32'h2000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF8001, 1'b0, 5'd5};
        tbl[6]  = '{"lhu",   32'h00005283, 32'h2002, 32'h0, 32'h0, 32'h80011234, 0, 1, 32'h2000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00008001, 1'b0, 5'd5};
        tbl[7]  = '{"lw_mis",32'h00002283, 32'h3002, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd5};
        tbl[8]  = '{"jal",   32'h000000EF, 32'h1234, 32'h0, 32'hFFFFFFFC, 32'h0, 0, 0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 5'd1};
        tbl[9]  = '{"jal_x0",32'h0000006F, 32'h1234, 32'h0, 32'hFFFFFFFC, 32'h0, 0, 0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0};
        tbl[10] = '{"lw_to", 32'h00002283, 32'h4000, 32'h0, 32'h0, 32'h0, -1, 4, 32'h4000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd5};
        tbl[11] = '{"sh",    32'h00001023, 32'h1002, 32'hCAFE1234, 32'h0, 32'h0, 0, 1, 32'h1000, 4'b1100, 1'b1, 1'b1, 32'h12341234, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0};
        tbl[12] = '{"sw_last",32'h00002023, 32'h1004, 32'hDEADBEEF, 32'h0, 32'h0, 3, 4, 32'h1004, 4'b1111, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0};
        tbl[13] = '{"sh_mis",32'h00001023, 32'h1001, 32'h55, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 5'd0};
        tbl[14] = '{"jalr",  32'h000003E7, 32'h9, 32'h0, 32'h00000100, 32'h0, 0, 0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 1'b0, 5'd7};
        tbl[15] = '{"branch",32'h000002E3, 32'h1, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd5};
        tbl[16] = '{"lui",   32'h000004B7, 32'hABCD0000, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hABCD0000, 1'b0, 5'd9};
        tbl[17] = '{"ld_f3_3",32'h00003303, 32'h5000, 32'h0, 32'h0, 32'h87654321, 0, 1, 32'h5000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h87654321, 1'b0, 5'd6};
        tbl[18] = '{"lw_x0", 32'h00002003, 32'h5004, 32'h0, 32'h0, 32'h0BADF00D, 0, 1, 32'h5004, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 5'd0};
        tbl[19] = '{"sb0",   32'h00000023, 32'h2000, 32'h5A, 32'h0, 32'h0, 0, 1, 32'h2000, 4'b0001, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0};

        rst_n = 1'b0; in_valid = 1'b0; IR = 0; alu_res = 0; B_res = 0; PC_res = 0;
        dmem_ack = 1'b0; dmem_rdata = 0;
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_we", 32'(dmem_we), 32'd0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'd0);
        chk("rst dmem_wdata", dmem_wdata, 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst wb_en", 32'(wb_en), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst wb_rd", 32'(wb_rd), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) run_vec(tbl[i], 1'b0);

        // Back-to-back non-memory bundles retire one per cycle
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; IR = {20'h0, 5'(k + 1), 7'b0010011}; alu_res = 32'(100 + k);
            @(negedge clk);
            chk("b2b out_valid", 32'(out_valid), 32'd1);
            chk("b2b wb_rd", 32'(wb_rd), 32'(k + 1));
            chk("b2b wb_data", wb_data, 32'(100 + k));
            chk("b2b in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b pulse", 32'(out_valid), 32'd0);

        // New bundle accepted in the same cycle a load retires
        in_valid = 1'b1; IR = 32'h00002203; alu_res = 32'h6000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("retire_acc req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hA5A50001;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("retire_acc ld", wb_data, 32'hA5A50001);
        chk("retire_acc ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; IR = 32'h00000413; alu_res = 32'h77;
        @(negedge clk);
        in_valid = 1'b0;
        chk("retire_acc next_valid", 32'(out_valid), 32'd1);
        chk("retire_acc next_rd", 32'(wb_rd), 32'd8);
        chk("retire_acc next_data", wb_data, 32'h77);
        chk("retire_acc no_req", 32'(dmem_req), 32'd0);

        // Reset during WAIT drops the request at once; a late ack is ignored
        @(negedge clk);
        in_valid = 1'b1; IR = 32'h00002103; alu_res = 32'h7000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstwait req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwait req_drop", 32'(dmem_req), 32'd0);
        chk("rstwait ready", 32'(in_ready), 32'd1);
        dmem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("rstwait late_ack valid", 32'(out_valid), 32'd0);
        chk("rstwait late_ack req", 32'(dmem_req), 32'd0);
        chk("rstwait ready_after", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("rstwait still_idle", 32'(out_valid), 32'd0);

        ops = '{7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011, 7'b0100011,
                7'b0100011, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0110011};
        for (int i = 0; i < 200; i++) begin
            ir = $urandom;
            ir[6:0] = ops[$urandom_range(0, 9)];
            alu = $urandom;
            if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            if (r < 7) r = r % 4;
            else if (r == 7) r = 3;
            else if (r == 8) r = 4;
            else r = -1;
            v = model(ir, alu, $urandom, $urandom, $urandom, r);
            v.name = $sformatf("rnd%0d", i);
            run_vec(v, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
